// File: rtl/interp_buf_pkg.sv
// Shared definitions for the transposed interpolation buffer controller:
// FSM state encoding, column-select code constants and default geometry.
package interp_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } buf_state_e;

  // Column-mux select code: 0 means "no column", 1..N address columns 1..N.
  localparam int               SEL_W    = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;

  localparam int DEF_NUM_ROWS = 4;
  localparam int DEF_NUM_COLS = 4;

endpackage

// File: rtl/buf_idx_counter.sv
// Wrap-at-limit index counter with enable, clear and load-one.
// Counts 0..LIMIT and wraps back to 0; clear dominates load-one, which
// dominates the increment.
module buf_idx_counter #(
  parameter int W     = 2,
  parameter int LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load_one,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  // Index register: synchronous clear, load-one, or wrapping increment.
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (en) begin
      count <= (count == LIM) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/buffer_column_read_ctrl.sv
// Transposed interpolation buffer sequencer: counts NUM_ROWS row writes from
// the horizontal filter, then walks the column-select mux through columns
// 1..NUM_COLS toward the vertical filter.
// Optional feature macro: BUF_CTRL_STALL_CNT_EN adds the stall_cnt output,
// a saturating count of READ cycles in which the consumer was not ready.
module buffer_column_read_ctrl
  import interp_buf_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int ROW_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_en,
  output logic             wr_ready,
  output logic [ROW_W-1:0] row_idx,
  input  logic             rd_ready,
  output logic [SEL_W-1:0] select,
  output logic             col_valid,
  output logic             col_last,
  output logic             block_done,
`ifdef BUF_CTRL_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             busy
);

  buf_state_e       state;
  logic [SEL_W-1:0] col;
  logic             start_ok;
  logic             row_wr;
  logic             row_last;
  logic             xfer;

  // START is only honoured between blocks; elsewhere it is ignored.
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  assign row_wr   = wr_ready && wr_en;
  assign row_last = (row_idx == ROW_W'(NUM_ROWS - 1));
  assign xfer     = col_valid && rd_ready;
  assign col_last = col_valid && (col == SEL_W'(NUM_COLS));
  assign select   = col_valid ? col : SEL_NONE;

  buf_idx_counter #(.W(ROW_W), .LIMIT(NUM_ROWS - 1)) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (row_wr),
    .clr      (start_ok),
    .load_one (1'b0),
    .count    (row_idx)
  );

  // The last row write preloads column 1; the last transfer wraps to 0.
  buf_idx_counter #(.W(SEL_W), .LIMIT(NUM_COLS)) u_col_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (xfer),
    .clr      (start_ok),
    .load_one (row_wr && row_last),
    .count    (col)
  );

  // Block sequencer with registered status flags tracking the next state.
  // NOTE: reset is synchronous and active-high, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ready   <= 1'b0;
      col_valid  <= 1'b0;
      block_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FILL;
            wr_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FILL: begin
          if (wr_en && row_last) begin
            state     <= ST_READ;
            wr_ready  <= 1'b0;
            col_valid <= 1'b1;
          end
        end
        ST_READ: begin
          if (xfer && col_last) begin
            state      <= ST_DONE;
            col_valid  <= 1'b0;
            block_done <= 1'b1;
          end
        end
        ST_DONE: begin
          block_done <= 1'b0;
          if (start) begin
            state    <= ST_FILL;
            wr_ready <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          wr_ready   <= 1'b0;
          col_valid  <= 1'b0;
          block_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUF_CTRL_STALL_CNT_EN
  // Saturating count of READ cycles where the consumer held off.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_cnt <= '0;
    end else if (col_valid && !rd_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_column_read_ctrl.sv
// Bench for buffer_column_read_ctrl: a default 4x4 instance and a 2-row,
// 7-column instance. Expected row indices and column selects are queued
// when stimulus is driven and popped as the design presents them.
module tb_buffer_column_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, wr_en, rd_ready;
  logic       wr_ready, col_valid, col_last, block_done, busy;
  logic [1:0] row_idx;
  logic [2:0] select;
  logic       w_start, w_wr_en, w_rd_ready;
  logic       w_wr_ready, w_col_valid, w_col_last, w_block_done, w_busy;
  logic [0:0] w_row_idx;
  logic [2:0] w_select;
`ifdef BUF_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt, w_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_row[$];
  int exp_sel[$];

  always #5 clk = ~clk;

  buffer_column_read_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_ready(wr_ready),
    .row_idx(row_idx), .rd_ready(rd_ready), .select(select),
    .col_valid(col_valid), .col_last(col_last), .block_done(block_done),
`ifdef BUF_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  buffer_column_read_ctrl #(.NUM_ROWS(2), .NUM_COLS(7), .ROW_W(1)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .wr_en(w_wr_en), .wr_ready(w_wr_ready),
    .row_idx(w_row_idx), .rd_ready(w_rd_ready), .select(w_select),
    .col_valid(w_col_valid), .col_last(w_col_last), .block_done(w_block_done),
`ifdef BUF_CTRL_STALL_CNT_EN
    .stall_cnt(w_stall_cnt),
`endif
    .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({wr_ready, col_valid, col_last, block_done, busy, row_idx, select} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_state: outs=%b want all zero",
               {wr_ready, col_valid, col_last, block_done, busy, row_idx, select});
    end
    n_vec++;
    if ({w_wr_ready, w_col_valid, w_col_last, w_block_done, w_busy, w_row_idx, w_select} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state_wide: outs=%b want all zero",
               {w_wr_ready, w_col_valid, w_col_last, w_block_done, w_busy, w_row_idx, w_select});
    end
`ifdef BUF_CTRL_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  // Runs one block on the 4x4 instance, starting at a point where START is
  // honoured (IDLE or DONE). Returns at the DONE sample point.
  task automatic run_block(input int stall_sel, input int stall_len, input bit noise,
                           output int cycles);
    int stalls_left;
    int stall_exp;
    int budget;
    int front;
    stalls_left = stall_len;
    stall_exp   = 0;
    cycles      = 0;
    start = 1'b1;
    for (int r = 0; r < 4; r++) exp_row.push_back(r);
    tick(); cycles++;
    start = 1'b0;
    n_vec++;
    if (wr_ready !== 1'b1 || busy !== 1'b1 || col_valid !== 1'b0 || block_done !== 1'b0) begin
      n_err++;
      $display("FAIL fill_entry: wr_ready=%b busy=%b col_valid=%b block_done=%b want 1 1 0 0",
               wr_ready, busy, col_valid, block_done);
    end
    budget = 0;
    while (exp_row.size() > 0 && budget < 20) begin
      budget++;
      n_vec++;
      if (row_idx !== 2'(exp_row[0]) || wr_ready !== 1'b1 || select !== 3'd0) begin
        n_err++;
        $display("FAIL fill_row: row_idx=%0d wr_ready=%b select=%0d want %0d 1 0",
                 row_idx, wr_ready, select, exp_row[0]);
      end
      wr_en = 1'b1;
      start = noise;
      if (exp_row.size() == 1) for (int c = 1; c <= 4; c++) exp_sel.push_back(c);
      void'(exp_row.pop_front());
      tick(); cycles++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    budget = 0;
    while (exp_sel.size() > 0 && budget < 40) begin
      budget++;
      front = exp_sel[0];
      n_vec++;
      if (col_valid !== 1'b1 || select !== 3'(front) || col_last !== (front == 4) ||
          row_idx !== 2'd0 || wr_ready !== 1'b0) begin
        n_err++;
        $display("FAIL read_col: valid=%b select=%0d last=%b row_idx=%0d wr_ready=%b want 1 %0d %0d 0 0",
                 col_valid, select, col_last, row_idx, wr_ready, front, front == 4);
      end
      if (front == stall_sel && stalls_left > 0) begin
        rd_ready = 1'b0;
        stalls_left--;
        stall_exp++;
      end else begin
        rd_ready = 1'b1;
        void'(exp_sel.pop_front());
      end
      wr_en = noise;
      start = noise;
      tick(); cycles++;
    end
    rd_ready = 1'b0;
    wr_en    = 1'b0;
    start    = 1'b0;
    n_vec++;
    if (exp_sel.size() != 0) begin
      n_err++;
      $display("FAIL read_timeout: %0d columns never presented", exp_sel.size());
      exp_sel.delete();
    end
    n_vec++;
    if (block_done !== 1'b1 || select !== 3'd0 || col_valid !== 1'b0 || col_last !== 1'b0 ||
        busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_state: block_done=%b select=%0d valid=%b last=%b busy=%b wr_ready=%b want 1 0 0 0 1 0",
               block_done, select, col_valid, col_last, busy, wr_ready);
    end
`ifdef BUF_CTRL_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, stall_exp);
    end
`endif
  endtask

  task automatic expect_idle(input string tag);
    tick();
    n_vec++;
    if (busy !== 1'b0 || block_done !== 1'b0 || wr_ready !== 1'b0 || select !== 3'd0) begin
      n_err++;
      $display("FAIL %s: busy=%b block_done=%b wr_ready=%b select=%0d want 0 0 0 0",
               tag, busy, block_done, wr_ready, select);
    end
  endtask

  task automatic check_len(input string tag, input int cycles, input int want);
    n_vec++;
    if (cycles != want) begin
      n_err++;
      $display("FAIL %s: block took %0d cycles want %0d", tag, cycles, want);
    end
  endtask

  task automatic test_basic_block();
    int cyc;
    run_block(0, 0, 1'b0, cyc);
    check_len("basic_len", cyc, 9);
    expect_idle("basic_idle");
  endtask

  task automatic test_stall();
    int cyc;
    run_block(2, 3, 1'b0, cyc);
    check_len("stall_len", cyc, 12);
    expect_idle("stall_idle");
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_block(0, 0, 1'b0, cyc);
    run_block(3, 1, 1'b0, cyc);
    check_len("b2b_len", cyc, 10);
    expect_idle("b2b_idle");
  endtask

  task automatic test_ignored_events();
    int cyc;
    run_block(0, 0, 1'b1, cyc);
    check_len("noise_len", cyc, 9);
    expect_idle("noise_idle");
  endtask

  task automatic test_reset_mid_read();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1;
    repeat (4) tick();
    wr_en    = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    n_vec++;
    if (select !== 3'b010 || col_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_sel: select=%b valid=%b want 010 1", select, col_valid);
    end
    rst = 1'b1; rd_ready = 1'b1; wr_en = 1'b1;
    tick();
    n_vec++;
    if ({wr_ready, col_valid, col_last, block_done, busy, row_idx, select} !== 9'd0) begin
      n_err++;
      $display("FAIL mid_reset: outs=%b want all zero",
               {wr_ready, col_valid, col_last, block_done, busy, row_idx, select});
    end
    tick();
    rst = 1'b0; rd_ready = 1'b0;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (wr_ready !== 1'b0 || row_idx !== 2'd0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL wr_after_reset: wr_ready=%b row_idx=%0d busy=%b want 0 0 0",
                 wr_ready, row_idx, busy);
      end
    end
    wr_en = 1'b0;
    exp_row.delete();
    exp_sel.delete();
  endtask

  task automatic test_wide();
    int budget;
    int front;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int r = 0; r < 2; r++) exp_row.push_back(r);
    budget = 0;
    while (exp_row.size() > 0 && budget < 10) begin
      budget++;
      n_vec++;
      if (w_wr_ready !== 1'b1 || w_row_idx !== 1'(exp_row[0])) begin
        n_err++;
        $display("FAIL wide_row: wr_ready=%b row_idx=%0d want 1 %0d", w_wr_ready, w_row_idx, exp_row[0]);
      end
      w_wr_en = 1'b1;
      if (exp_row.size() == 1) for (int c = 1; c <= 7; c++) exp_sel.push_back(c);
      void'(exp_row.pop_front());
      tick();
    end
    w_wr_en = 1'b0;
    budget = 0;
    while (exp_sel.size() > 0 && budget < 200) begin
      budget++;
      front = exp_sel[0];
      n_vec++;
      if (w_col_valid !== 1'b1 || w_select === 3'd0 || w_select !== 3'(front) ||
          w_col_last !== (front == 7)) begin
        n_err++;
        $display("FAIL wide_col: valid=%b select=%0d last=%b want 1 %0d %0d",
                 w_col_valid, w_select, w_col_last, front, front == 7);
      end
      w_rd_ready = 1'($urandom_range(0, 1));
      if (w_rd_ready) void'(exp_sel.pop_front());
      tick();
    end
    w_rd_ready = 1'b0;
    n_vec++;
    if (exp_sel.size() != 0 || w_block_done !== 1'b1 || w_select !== 3'd0 || w_col_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wide_done: left=%0d block_done=%b select=%0d valid=%b want 0 1 0 0",
               exp_sel.size(), w_block_done, w_select, w_col_valid);
      exp_sel.delete();
    end
    tick();
    n_vec++;
    if (w_busy !== 1'b0 || w_block_done !== 1'b0) begin
      n_err++;
      $display("FAIL wide_idle: busy=%b block_done=%b want 0 0", w_busy, w_block_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
    w_start = 1'b0; w_wr_en = 1'b0; w_rd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_basic_block();
    test_stall();
    test_back_to_back();
    test_ignored_events();
    test_reset_mid_read();
    test_basic_block();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
